// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and frame layout for the SPI memory responder
package spi_pkg;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int CMD_BITS   = DEF_ADDR_W + 1;
  localparam int FRAME_BITS = CMD_BITS + DEF_DATA_W;
  localparam int WR_POS     = 0;
  localparam int ADDR_LSB   = 1;
  localparam int DATA_LSB   = CMD_BITS;
  typedef enum logic [2:0] {IDLE, RX_CMD, RX_DATA, WAIT_CS, RD_LOAD, RD_HOLD, TX} state_t;
endpackage

// File: rtl/spi_regfile.sv
// spi_regfile: DEPTH x DATA_W register array, synchronous write and clear, combinational read
module spi_regfile #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // clear everything on reset, otherwise commit one word per write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI target decoding LSB-first write/read frames into a register file
module spi_mem_responder import spi_pkg::*; #(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done
);
  localparam int CB = ADDR_W + 1;
  localparam int CW = $clog2((CB > DATA_W ? CB : DATA_W) + 1);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic wr, wr_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-2:0] dat, dat_n;
  logic [DATA_W-1:0] tx, tx_n, rdata, wdata;
  logic miso_n, ready_n, done_n, we, hit;
  // addresses beyond the array read as zero and swallow writes
  assign hit = 32'(addr) < 32'(DEPTH);
  assign wdata = {mosi, dat};
  spi_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_regfile (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(addr[AW-1:0]),
    .wdata(wdata),
    .raddr(addr[AW-1:0]),
    .rdata(rdata)
  );
  // state and datapath registers; reset also aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr      <= 1'b0;
      addr    <= '0;
      dat     <= '0;
      tx      <= '0;
      miso    <= 1'b0;
      ready   <= 1'b0;
      op_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      wr      <= wr_n;
      addr    <= addr_n;
      dat     <= dat_n;
      tx      <= tx_n;
      miso    <= miso_n;
      ready   <= ready_n;
      op_done <= done_n;
    end
  end
  // frame sequencing: address and data bits shift in from the top so LSB-first lands in place
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = wr;
    addr_n  = addr;
    dat_n   = dat;
    tx_n    = tx;
    miso_n  = 1'b0;
    ready_n = 1'b0;
    done_n  = 1'b0;
    we      = 1'b0;
    case (state)
      IDLE: begin
        state_n = cs ? IDLE : RX_CMD;
        cnt_n   = '0;
      end
      RX_CMD: begin
        if (cs) begin
          state_n = IDLE;
        end else begin
          cnt_n  = cnt + CW'(1);
          wr_n   = (cnt == '0) ? mosi : wr;
          addr_n = (cnt == '0) ? addr : {mosi, addr[ADDR_W-1:1]};
          if (cnt == CW'(CB - 1)) begin
            state_n = wr ? RX_DATA : RD_LOAD;
            cnt_n   = '0;
          end
        end
      end
      RX_DATA: begin
        if (cs) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
          dat_n = {mosi, dat[DATA_W-2:1]};
          if (cnt == CW'(DATA_W - 1)) begin
            we      = hit;
            done_n  = 1'b1;
            state_n = WAIT_CS;
          end
        end
      end
      WAIT_CS: state_n = cs ? IDLE : WAIT_CS;
      RD_LOAD: begin
        tx_n    = hit ? rdata : '0;
        miso_n  = tx_n[0];
        ready_n = 1'b1;
        state_n = RD_HOLD;
      end
      RD_HOLD: begin
        miso_n  = tx[0];
        cnt_n   = '0;
        state_n = TX;
      end
      TX: begin
        tx_n   = tx >> 1;
        cnt_n  = cnt + CW'(1);
        miso_n = (cnt == CW'(DATA_W - 1)) ? 1'b0 : tx[1];
        state_n = (cnt == CW'(DATA_W - 1)) ? IDLE : TX;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- SPI responder (target) for the team's 17-bit register-access SPI controller.
- Deserialises LSB-first frames on mosi while cs is low, and holds a DEPTH x DATA_W register file.
- Write frames: stores the data byte and pulses op_done.
- Read frames: pulses ready, then shifts the stored byte out on miso, LSB first.
- Sits at the far end of the cs/mosi/miso/ready/op_done wires from the controller; everything is single-clock.

Parameters:
- DEPTH, 32, number of registers; valid addresses are 0..DEPTH-1.
- ADDR_W, 8, address field width in the frame.
- DATA_W, 8, data field width in the frame and register width.

Ports:
- clk  input  1  clock; all sampling and driving on posedge.
- rst  input  1  reset, synchronous, active-high.
- cs  input  1  chip select, active low.
- mosi  input  1  serial data from the controller, LSB first.
- miso  output  1  serial read data to the controller, LSB first.
- ready  output  1  one-cycle pulse: read data is about to be shifted out.
- op_done  output  1  one-cycle pulse: write committed.

Behaviour:
- Reset (rst=1 at posedge, priority over everything):
  - state=IDLE; miso=0, ready=0, op_done=0; bit counter=0; shift registers=0.
  - All registers cleared to 0.
  - Reset mid-frame aborts the frame with no register update.
- Frame format, LSB first: bit0=wr, bits[ADDR_W:1]=addr, bits[ADDR_W+DATA_W:ADDR_W+1]=data. Read frames stop after the ADDR_W+1 command bits.
- IDLE: at the edge where cs is sampled 0 -> RX_CMD, cnt=0. mosi at this edge is ignored; the first data bit arrives one cycle after cs falls.
- RX_CMD: each edge captures mosi into cmd[cnt], cnt++. At the edge capturing cmd bit ADDR_W (9th bit):
  - wr=1 -> RX_DATA, cnt=0.
  - wr=0 -> RD_LOAD.
- RX_DATA: each edge captures mosi into data[cnt]. At the edge capturing data bit DATA_W-1:
  - mem[addr] <= data, op_done<=1, -> WAIT_CS.
  - If addr>=DEPTH: the write is dropped but op_done still pulses.
- Abort: cs sampled 1 in RX_CMD or RX_DATA -> IDLE, no write, no pulse.
- WAIT_CS: op_done<=0. Stay until cs sampled 1, then -> IDLE. This prevents a re-trigger from a stale low cs.
- RD_LOAD (one cycle):
  - tx <= mem[addr], or 0 if addr>=DEPTH.
  - miso<=that value's bit0, ready<=1, -> RD_HOLD.
  - cs state is ignored from here through the TX states.
- RD_HOLD (one cycle): ready<=0, miso holds bit0, cnt=0, -> TX.
- TX: each edge drives miso<=tx[cnt+1] and does cnt++. At the edge where cnt==DATA_W-1: miso<=0, -> IDLE.
- Read timing relative to the last command bit sampled at edge X:
  - ready high during cycle X+1..X+2.
  - miso=b0 across edges X+1..X+3.
  - bit k is valid at sampling edge X+3+k.
  - Total: last read bit is sampled at X+10, and the responder is back in IDLE at that same edge.
- Write latency: op_done rises at the edge capturing the final data bit and is high for exactly one cycle.
- Back-to-back: after returning to IDLE, the responder accepts a new cs fall on the very next edge.
- Width rules: addr compared unsigned against DEPTH. Only log2(DEPTH) low bits index the memory after the range check.
- ready and op_done are never high simultaneously. miso=0 whenever not in RD_LOAD/RD_HOLD/TX.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, RX_CMD, RX_DATA, WAIT_CS, RD_LOAD, RD_HOLD, TX}.
  - Constants CMD_BITS=ADDR_W+1, FRAME_BITS=CMD_BITS+DATA_W.
  - Bit-position constants for wr/addr/data.
- Sub-module spi_regfile:
  - DEPTH x DATA_W synchronous-write, combinational-read array with synchronous clear on rst.
  - Ports: we, waddr, wdata, raddr, rdata.

Test Plan:
- Write then read: drive write frame addr=0x05, data=0xA7 -> op_done single pulse at final-bit edge. Then read frame addr=0x05 -> ready pulse, then miso bits 1,1,1,0,0,1,0,1 at edges X+3..X+10 (0xA7).
- Read of unwritten register addr=0x1F after reset -> ready pulses, 8 sampled bits all 0 (0x00).
- Out-of-range write addr=0x40, data=0xFF -> op_done still pulses. Subsequent reads of addr=0x00 and addr=0x1F return 0x00; a read of addr=0x40 returns 0x00.
- Abort: cs raised after 5 write-data bits (addr=0x03, data=0x5A) -> no op_done. A read of 0x03 returns the prior value 0x00, and the responder accepts the next frame immediately.
- Reset mid-read: assert rst during TX after 3 bits -> miso=0, ready=0 next cycle. A follow-up read of a previously written 0x3C returns 0x00 (memory cleared).
- Back-to-back writes to addresses 0x00..0x1F with data=addr^0x55, then read all -> every read returns addr^0x55; exactly 32 op_done pulses.
